trace_event_logger: RTL and testbench

- Hardware counterpart of the debug/info/warn print helpers in utils_pkg.
- Sits directly upstream of the host-side log drain and downstream of any block raising debug events.
- Captures severity-tagged events, filters them against a runtime threshold, stamps each with a free-running cycle timestamp, and buffers them in a FIFO.
- Presents buffered entries as a valid/ready stream; counts events lost to overflow.

---
 rtl/trace_event_logger_if.sv | 44 ++++
 rtl/trace_event_logger.sv | 154 +++++++++++++++
 tb/tb_trace_event_logger.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/trace_event_logger_if.sv
// -----------------------------------------------------------------------------
// trace_event_logger_if
//   Bundles every non-clock, non-reset signal of trace_event_logger.
//   master : the surrounding system (event source, log drain, configuration)
//   slave  : the logger itself
//
//   Event side   : cfg_level, ev_valid, ev_sev, ev_msg
//   Stream side  : out_valid, out_ready, out_sev, out_ts, out_msg, out_ovf
//   Status side  : fill, drop_cnt, drop_clr
// -----------------------------------------------------------------------------
interface trace_event_logger_if #(
    parameter int MSG_W  = 32,
    parameter int TS_W   = 32,
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
);
    localparam int FILL_W = $clog2(DEPTH) + 1;

    logic [1:0]        cfg_level;
    logic              ev_valid;
    logic [1:0]        ev_sev;
    logic [MSG_W-1:0]  ev_msg;

    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_sev;
    logic [TS_W-1:0]   out_ts;
    logic [MSG_W-1:0]  out_msg;
    logic              out_ovf;

    logic [FILL_W-1:0] fill;
    logic [DROP_W-1:0] drop_cnt;
    logic              drop_clr;

    modport master (
        output cfg_level, ev_valid, ev_sev, ev_msg, out_ready, drop_clr,
        input  out_valid, out_sev, out_ts, out_msg, out_ovf, fill, drop_cnt
    );

    modport slave (
        input  cfg_level, ev_valid, ev_sev, ev_msg, out_ready, drop_clr,
        output out_valid, out_sev, out_ts, out_msg, out_ovf, fill, drop_cnt
    );
endinterface

// File: rtl/trace_event_logger.sv
// -----------------------------------------------------------------------------
// trace_event_logger
//   Captures severity-tagged debug events, filters them against a runtime
//   threshold, stamps each with a free-running cycle timestamp and buffers
//   them in a first-word-fall-through FIFO drained as a valid/ready stream.
//   Events arriving while the FIFO is full (and not popping) are dropped,
//   counted in a saturating counter, and flagged on the next stored entry.
//
//   Ports
//     clk  : single clock, rising edge
//     rst  : synchronous, active-high reset
//     bus  : trace_event_logger_if.slave
//            cfg_level  threshold (0=DEBUG,1=INFO,2=WARN,3=off)
//            ev_*       event strobe / severity / payload, no backpressure
//            out_*      head entry of the FIFO, valid/ready handshake
//            fill       occupancy 0..DEPTH
//            drop_cnt   saturating count of dropped events, drop_clr clears
// -----------------------------------------------------------------------------
module trace_event_logger #(
    parameter int MSG_W  = 32,
    parameter int TS_W   = 32,
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    trace_event_logger_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    // Entry layout, MSB first: {sev[1:0], ts, msg, ovf}
    localparam int EW = 2 + TS_W + MSG_W + 1;

    localparam logic [1:0]    SEV_RSVD  = 2'd3;
    localparam logic [1:0]    LVL_OFF   = 2'd3;
    localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + DROP_W'(1);
    endfunction

    // Control state
    logic [TS_W-1:0]   ts_q,          ts_d;
    logic [AW-1:0]     wr_ptr_q,      wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q,      rd_ptr_d;
    logic [FW-1:0]     fill_q,        fill_d;
    logic [DROP_W-1:0] drop_cnt_q,    drop_cnt_d;
    logic              pending_ovf_q, pending_ovf_d;

    // Storage (not reset)
    logic [EW-1:0]     mem_q [DEPTH];

    logic              qualify;
    logic              empty;
    logic              full;
    logic              pop;
    logic              wr_en;
    logic              drop;
    logic [EW-1:0]     wr_entry;
    logic [EW-1:0]     head;

    always_comb begin
        qualify = bus.ev_valid
                  && (bus.ev_sev != SEV_RSVD)
                  && (bus.cfg_level != LVL_OFF)
                  && (bus.ev_sev >= bus.cfg_level);

        empty = (fill_q == '0);
        full  = (fill_q == FILL_FULL);
        pop   = !empty && bus.out_ready;

        // A full FIFO still accepts a write when the head leaves this cycle.
        wr_en = qualify && (!full || pop);
        drop  = qualify && full && !pop;

        wr_entry = {bus.ev_sev, ts_q, bus.ev_msg, pending_ovf_q};
    end

    always_comb begin
        ts_d          = ts_q + TS_W'(1);
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        fill_d        = fill_q;
        drop_cnt_d    = drop_cnt_q;
        pending_ovf_d = pending_ovf_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        unique case ({wr_en, pop})
            2'b10:   fill_d = fill_q + FW'(1);
            2'b01:   fill_d = fill_q - FW'(1);
            default: fill_d = fill_q;
        endcase

        // Clear takes priority over the old value, but a drop in the same
        // cycle must still be counted.
        if (bus.drop_clr) begin
            drop_cnt_d = drop ? DROP_W'(1) : '0;
        end else if (drop) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
        end

        // A drop and a write can never coincide (drop implies no write).
        if (drop) begin
            pending_ovf_d = 1'b1;
        end else if (wr_en) begin
            pending_ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q          <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fill_q        <= '0;
            drop_cnt_q    <= '0;
            pending_ovf_q <= 1'b0;
        end else begin
            ts_q          <= ts_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fill_q        <= fill_d;
            drop_cnt_q    <= drop_cnt_d;
            pending_ovf_q <= pending_ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // Fall-through read: the head entry is presented combinationally.
    assign head = mem_q[rd_ptr_q];

    assign bus.out_valid = !empty;
    assign bus.out_sev   = head[EW-1 -: 2];
    assign bus.out_ts    = head[MSG_W+1 +: TS_W];
    assign bus.out_msg   = head[1 +: MSG_W];
    assign bus.out_ovf   = head[0];
    assign bus.fill      = fill_q;
    assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_trace_event_logger.sv
module tb_trace_event_logger;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    trace_event_logger_if #(.MSG_W(32), .TS_W(32), .DEPTH(16), .DROP_W(16)) bus1 ();
    trace_event_logger_if #(.MSG_W(32), .TS_W(32), .DEPTH(2),  .DROP_W(4))  bus2 ();

    trace_event_logger #(.MSG_W(32), .TS_W(32), .DEPTH(16), .DROP_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    trace_event_logger #(.MSG_W(32), .TS_W(32), .DEPTH(2), .DROP_W(4)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    typedef struct {
        logic [1:0]  sev;
        logic [31:0] ts;
        logic [31:0] msg;
        logic        ovf;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] ts_m;

    // Reference cycle counter: zero after any reset edge, +1 otherwise.
    always @(posedge clk) ts_m <= rst ? 32'd0 : ts_m + 32'd1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one event on the main DUT for one cycle; optionally record it.
    task automatic ev1(input logic [1:0] sev, input logic [31:0] msg,
                       input bit push, input bit ovf);
        exp_t e;
        bus1.ev_valid = 1'b1;
        bus1.ev_sev   = sev;
        bus1.ev_msg   = msg;
        if (push) begin
            e.sev = sev; e.ts = ts_m; e.msg = msg; e.ovf = ovf;
            sb_q.push_back(e);
        end
        tick();
        bus1.ev_valid = 1'b0;
    endtask

    task automatic drain1(input int n);
        bus1.out_ready = 1'b1;
        repeat (n) tick();
        bus1.out_ready = 1'b0;
    endtask

    // Monitor: every accepted head entry is checked against the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus1.out_valid && bus1.out_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL pop_unexpected: got msg 0x%0h expected no entry", bus1.out_msg);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("pop_sev", 64'(bus1.out_sev), 64'(e.sev));
                chk("pop_ts",  64'(bus1.out_ts),  64'(e.ts));
                chk("pop_msg", 64'(bus1.out_msg), 64'(e.msg));
                chk("pop_ovf", 64'(bus1.out_ovf), 64'(e.ovf));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst = 1'b1;
        bus1.cfg_level = 2'd0; bus1.ev_valid = 1'b0; bus1.ev_sev = 2'd0;
        bus1.ev_msg = '0; bus1.out_ready = 1'b0; bus1.drop_clr = 1'b0;
        bus2.cfg_level = 2'd0; bus2.ev_valid = 1'b0; bus2.ev_sev = 2'd0;
        bus2.ev_msg = '0; bus2.out_ready = 1'b0; bus2.drop_clr = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", 64'(bus1.out_valid), 64'd0);
        chk("rst_fill",      64'(bus1.fill),      64'd0);
        chk("rst_drop_cnt",  64'(bus1.drop_cnt),  64'd0);

        // 1: single INFO event stamped at ts=5
        repeat (5) tick();
        e.sev = 2'd1; e.ts = 32'd5; e.msg = 32'hA5A5_0001; e.ovf = 1'b0;
        sb_q.push_back(e);
        bus1.ev_valid = 1'b1; bus1.ev_sev = 2'd1; bus1.ev_msg = 32'hA5A5_0001;
        tick();
        bus1.ev_valid = 1'b0;
        chk("t1_out_valid", 64'(bus1.out_valid), 64'd1);
        chk("t1_fill",      64'(bus1.fill),      64'd1);
        drain1(1);
        chk("t1_fill_drained", 64'(bus1.fill), 64'd0);

        // 2: threshold WARN, severities 0..3 back to back
        bus1.cfg_level = 2'd2;
        for (int s = 0; s < 4; s++) begin
            bus1.ev_valid = 1'b1;
            bus1.ev_sev   = 2'(s);
            bus1.ev_msg   = 32'h2000 + 32'(s);
            if (s == 2) begin
                e.sev = 2'd2; e.ts = ts_m; e.msg = 32'h2002; e.ovf = 1'b0;
                sb_q.push_back(e);
            end
            tick();
        end
        bus1.ev_valid = 1'b0;
        chk("t2_fill",     64'(bus1.fill),     64'd1);
        chk("t2_drop_cnt", 64'(bus1.drop_cnt), 64'd0);
        // threshold off: even WARN is discarded
        bus1.cfg_level = 2'd3;
        ev1(2'd2, 32'h2F00, 1'b0, 1'b0);
        chk("t2_off_fill", 64'(bus1.fill), 64'd1);
        bus1.cfg_level = 2'd0;
        drain1(1);
        chk("t2_fill_drained", 64'(bus1.fill), 64'd0);

        // 3: 18 events into 16 entries, then push+pop on a full FIFO
        for (int i = 0; i < 18; i++) begin
            ev1(2'(i % 3), 32'h3000 + 32'(i), i < 16, 1'b0);
        end
        chk("t3_fill",     64'(bus1.fill),     64'd16);
        chk("t3_drop_cnt", 64'(bus1.drop_cnt), 64'd2);
        // 4: full, out_ready=1 and an event in the same cycle
        bus1.out_ready = 1'b1;
        ev1(2'd2, 32'h3100, 1'b1, 1'b1);
        chk("t4_fill",     64'(bus1.fill),     64'd16);
        chk("t4_drop_cnt", 64'(bus1.drop_cnt), 64'd2);
        drain1(16);
        chk("t3_fill_drained",  64'(bus1.fill),      64'd0);
        chk("t3_valid_drained", 64'(bus1.out_valid), 64'd0);

        // 5: drop_cnt to 7, then clear in the same cycle as a drop
        for (int i = 0; i < 16; i++) begin
            ev1(2'd1, 32'h5000 + 32'(i), 1'b1, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            ev1(2'd1, 32'h5100 + 32'(i), 1'b0, 1'b0);
        end
        chk("t5_drop_cnt7", 64'(bus1.drop_cnt), 64'd7);
        bus1.drop_clr = 1'b1;
        ev1(2'd0, 32'h5200, 1'b0, 1'b0);
        bus1.drop_clr = 1'b0;
        chk("t5_clr_with_drop", 64'(bus1.drop_cnt), 64'd1);
        drain1(16);
        // pending overflow survives drop_clr and tags the next entry
        ev1(2'd2, 32'h5300, 1'b1, 1'b1);
        drain1(1);
        chk("t5_fill_drained", 64'(bus1.fill), 64'd0);

        // 5b: DROP_W=4 saturation on the small instance (DEPTH=2)
        bus2.ev_sev = 2'd1;
        for (int i = 0; i < 17; i++) begin
            bus2.ev_valid = 1'b1;
            bus2.ev_msg   = 32'(i);
            tick();
        end
        bus2.ev_valid = 1'b0;
        chk("t5_sat_15drops", 64'(bus2.drop_cnt), 64'd15);
        for (int i = 0; i < 5; i++) begin
            bus2.ev_valid = 1'b1;
            tick();
        end
        bus2.ev_valid = 1'b0;
        chk("t5_sat_hold", 64'(bus2.drop_cnt), 64'd15);
        chk("t5_sat_fill", 64'(bus2.fill),     64'd2);
        bus2.drop_clr = 1'b1;
        tick();
        bus2.drop_clr = 1'b0;
        chk("t5_sat_clr", 64'(bus2.drop_cnt), 64'd0);

        // 6: reset with five entries buffered
        for (int i = 0; i < 5; i++) begin
            ev1(2'd1, 32'h6000 + 32'(i), 1'b0, 1'b0);
        end
        chk("t6_fill_pre", 64'(bus1.fill), 64'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_out_valid", 64'(bus1.out_valid), 64'd0);
        chk("t6_fill",      64'(bus1.fill),      64'd0);
        chk("t6_drop_cnt",  64'(bus1.drop_cnt),  64'd0);
        e.sev = 2'd2; e.ts = 32'd0; e.msg = 32'h6100; e.ovf = 1'b0;
        sb_q.push_back(e);
        bus1.ev_valid = 1'b1; bus1.ev_sev = 2'd2; bus1.ev_msg = 32'h6100;
        tick();
        bus1.ev_valid = 1'b0;
        drain1(1);

        // out_ready on an empty FIFO has no effect
        drain1(2);
        chk("end_fill",      64'(bus1.fill),      64'd0);
        chk("end_out_valid", 64'(bus1.out_valid), 64'd0);
        chk("sb_left",       64'(sb_q.size()),    64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
